// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings, FSM states and alignment rule for data_mem_stage
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic logic alignment_ok(input logic [1:0] size, input logic [1:0] lo);
        return size == SZ_BYTE ? 1'b1 : size == SZ_HALF ? ~lo[0] : lo == 2'b00;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// load_store_align: byte-lane steering for stores and lane select plus extension for loads
//   i_size/i_lo/i_signed : access size, address[1:0], sign-extend flag
//   i_wdata -> o_be/o_wdata : store byte enables and replicated store data
//   i_rword -> o_rdata      : addressed word -> extended load result
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lo,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = i_rword[{i_lo, 3'b000} +: 8];
        w_half  = i_lo[1] ? i_rword[31:16] : i_rword[15:0];
        o_be    = i_size == SZ_BYTE ? 4'b0001 << i_lo :
                  i_size == SZ_HALF ? (i_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        o_wdata = i_size == SZ_BYTE ? {4{i_wdata[7:0]}} :
                  i_size == SZ_HALF ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata = i_size == SZ_BYTE ? {{24{i_signed & w_byte[7]}}, w_byte} :
                  i_size == SZ_HALF ? {{16{i_signed & w_half[15]}}, w_half} : i_rword;
    end

endmodule

// File: rtl/data_mem_stage.sv
// data_mem_stage: MIPS MEM stage with a word-organised data RAM of LATENCY-cycle access
//   Clk_in/Rst_in          : clock, synchronous active-high reset
//   MemRead_in/MemWrite_in : load/store request (store wins when both set)
//   MemSize_in/MemSigned_in: byte/half/word, sign-extend sub-word loads
//   Address_in/WriteData_in: byte address, store data
//   ReadData_out           : registered load result, held until the next load completes
//   Stall_out              : hold upstream while an access is in flight
//   Done_out               : one-cycle pulse while the access completes
//   Misaligned_out         : request with illegal alignment (ignored, no stall)
//   MEM_STATS_EN           : when defined, adds LoadCount_out/StoreCount_out
module data_mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
)(
    input  logic        Clk_in,
    input  logic        Rst_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MemSize_in,
    input  logic        MemSigned_in,
    input  logic [31:0] Address_in,
    input  logic [31:0] WriteData_in,
    output logic [31:0] ReadData_out,
    output logic        Stall_out,
    output logic        Done_out,
    output logic        Misaligned_out
`ifdef MEM_STATS_EN
    ,
    output logic [31:0] LoadCount_out,
    output logic [31:0] StoreCount_out
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e         r_state;
    state_e         w_next;
    logic [3:0]     r_cnt;
    logic [AW-1:0]  r_idx;
    logic [1:0]     r_lo;
    logic [1:0]     r_size;
    logic           r_signed;
    logic           r_write;
    logic [31:0]    r_wdata;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic           w_idle;
    logic           w_req;
    logic           w_commit;
    logic [AW-1:0]  w_idx;
    logic [1:0]     w_lo;
    logic [1:0]     w_size;
    logic           w_signed;
    logic           w_write;
    logic [31:0]    w_wdata_in;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic [31:0]    w_rdata;
    logic           w_unused_addr;

    assign w_unused_addr  = ^Address_in[31:AW+2];
    assign Misaligned_out = (MemRead_in | MemWrite_in) & ~alignment_ok(MemSize_in, Address_in[1:0]);
    assign w_req          = (MemRead_in | MemWrite_in) & ~Misaligned_out;
    assign w_idle         = r_state == IDLE;

    // In IDLE the live inputs drive the access (needed when LATENCY==1 commits from IDLE);
    // afterwards the fields captured at acceptance are used.
    assign w_idx      = w_idle ? Address_in[AW+1:2] : r_idx;
    assign w_lo       = w_idle ? Address_in[1:0]    : r_lo;
    assign w_size     = w_idle ? MemSize_in         : r_size;
    assign w_signed   = w_idle ? MemSigned_in       : r_signed;
    assign w_write    = w_idle ? MemWrite_in        : r_write;
    assign w_wdata_in = w_idle ? WriteData_in       : r_wdata;

    assign w_commit = (w_idle & w_req & (LATENCY == 1)) | (r_state == BUSY & r_cnt == 4'd1);

    load_store_align u_align (
        .i_size   (w_size),
        .i_lo     (w_lo),
        .i_signed (w_signed),
        .i_wdata  (w_wdata_in),
        .i_rword  (r_mem[w_idx]),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata)
    );

    always_ff @(posedge Clk_in) begin
        if (Rst_in) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            ReadData_out <= '0;
            Done_out     <= 1'b0;
        end else begin
            r_state  <= w_next;
            Done_out <= w_commit;
            if (w_idle && w_req)
                r_cnt <= 4'(LATENCY - 1);
            else if (r_state == BUSY)
                r_cnt <= r_cnt - 4'd1;
            if (w_commit && !w_write)
                ReadData_out <= w_rdata;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_idle && w_req)
            w_next = (LATENCY == 1) ? DONE : BUSY;
        else if (r_state == BUSY && r_cnt == 4'd1)
            w_next = DONE;
        else if (r_state == DONE)
            w_next = IDLE;
    end

    always_comb begin
        Stall_out = w_idle ? w_req : r_state == BUSY;
    end

    // Request capture and RAM write; a reset on the commit edge aborts the store.
    always_ff @(posedge Clk_in) begin
        if (w_idle) begin
            r_idx    <= Address_in[AW+1:2];
            r_lo     <= Address_in[1:0];
            r_size   <= MemSize_in;
            r_signed <= MemSigned_in;
            r_write  <= MemWrite_in;
            r_wdata  <= WriteData_in;
        end
        if (w_commit && w_write && !Rst_in)
            for (int b = 0; b < 4; b++)
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge Clk_in) begin
        if (Rst_in) begin
            LoadCount_out  <= '0;
            StoreCount_out <= '0;
        end else if (w_commit) begin
            LoadCount_out  <= LoadCount_out  + {31'd0, ~w_write};
            StoreCount_out <= StoreCount_out + {31'd0, w_write};
        end
    end
`endif

endmodule
